// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand stage bus.
// Groups the stage's stimulus (stall/flush, decoded ID fields, EX/MEM and
// MEM/WB write-back taps) and its results (ALU operands and control,
// registered EX controls, load-use stall, bubble count).
//   master : the pipeline side that drives ID fields and forwarding taps
//   slave  : the operand stage itself
interface id_ex_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [DATA_W-1:0] id_rs1_data;
  logic [DATA_W-1:0] id_rs2_data;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rs1_addr;
  logic [REG_AW-1:0] id_rs2_addr;
  logic [REG_AW-1:0] id_rd_addr;
  logic              id_alusrc;
  logic [CTRL_W-1:0] id_aluctrl;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_memwrite;
  logic              id_memtoreg;
  logic              exmem_regwrite;
  logic [REG_AW-1:0] exmem_rd;
  logic [DATA_W-1:0] exmem_data;
  logic              memwb_regwrite;
  logic [REG_AW-1:0] memwb_rd;
  logic [DATA_W-1:0] memwb_data;

  logic [DATA_W-1:0] alu_data1;
  logic [DATA_W-1:0] alu_data2;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_valid;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_memtoreg;
  logic              load_use_stall;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output stall, flush, id_valid, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_alusrc, id_aluctrl,
           id_regwrite, id_memread, id_memwrite, id_memtoreg,
           exmem_regwrite, exmem_rd, exmem_data,
           memwb_regwrite, memwb_rd, memwb_data,
    input  alu_data1, alu_data2, alu_ctrl, ex_store_data, ex_rd, ex_valid,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
           load_use_stall, bubble_cnt
  );

  modport slave (
    input  stall, flush, id_valid, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_alusrc, id_aluctrl,
           id_regwrite, id_memread, id_memwrite, id_memtoreg,
           exmem_regwrite, exmem_rd, exmem_data,
           memwb_regwrite, memwb_rd, memwb_data,
    output alu_data1, alu_data2, alu_ctrl, ex_store_data, ex_rd, ex_valid,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
           load_use_stall, bubble_cnt
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding.
// Latches decoded operands/controls from ID, resolves RAW hazards from the
// EX/MEM and MEM/WB taps, detects load-use hazards (inserting a bubble and
// asking ID/PC to hold), honours cache stalls and branch flushes.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : id_ex_operand_stage_if slave (ID fields, forwarding taps, ALU side)
module id_ex_operand_stage #(
  parameter int              DATA_W  = 32,
  parameter int              REG_AW  = 5,
  parameter int              CTRL_W  = 4,
  parameter logic [CTRL_W-1:0] ALU_NOP = 4'b0010,
  parameter int              CNT_W   = 16
) (
  input logic                  clk_i,
  input logic                  rst_i,
  id_ex_operand_stage_if.slave bus
);

  logic              ex_valid;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_memtoreg;
  logic              ex_alusrc;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [REG_AW-1:0] ex_rd;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [DATA_W-1:0] ex_rs1_data;
  logic [DATA_W-1:0] ex_rs2_data;
  logic [DATA_W-1:0] ex_imm;
  logic              flush_pend;
  logic [CNT_W-1:0]  bubble_cnt;

  logic              load_use;
  logic [DATA_W-1:0] fwd_rs1;
  logic [DATA_W-1:0] fwd_rs2;

  assign load_use = ex_valid && ex_memread && (ex_rd != '0) &&
                    ((ex_rd == bus.id_rs1_addr) || (ex_rd == bus.id_rs2_addr)) &&
                    bus.id_valid && !bus.stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_ctrl     <= ALU_NOP;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      flush_pend  <= 1'b0;
      bubble_cnt  <= '0;
    end else if (bus.stall) begin
      // A flush arriving while the cache holds us must not be lost.
      if (bus.flush) flush_pend <= 1'b1;
    end else if (bus.flush || flush_pend || load_use) begin
      // Squash and load-use bubble share the same control clear; data
      // registers keep their old contents since nothing consumes them.
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_ctrl     <= ALU_NOP;
      flush_pend  <= 1'b0;
      // Only load-use bubbles are counted, never flush squashes.
      if (!(bus.flush || flush_pend) && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      ex_valid    <= bus.id_valid;
      ex_regwrite <= bus.id_regwrite;
      ex_memread  <= bus.id_memread;
      ex_memwrite <= bus.id_memwrite;
      ex_memtoreg <= bus.id_memtoreg;
      ex_alusrc   <= bus.id_alusrc;
      ex_ctrl     <= bus.id_aluctrl;
      ex_rd       <= bus.id_rd_addr;
      ex_rs1      <= bus.id_rs1_addr;
      ex_rs2      <= bus.id_rs2_addr;
      ex_rs1_data <= bus.id_rs1_data;
      ex_rs2_data <= bus.id_rs2_data;
      ex_imm      <= bus.id_imm;
    end
  end

  // EX/MEM is the younger producer, so it is checked first.
  always_comb begin
    fwd_rs1 = ex_rs1_data;
    if (bus.exmem_regwrite && (bus.exmem_rd != '0) && (bus.exmem_rd == ex_rs1))
      fwd_rs1 = bus.exmem_data;
    else if (bus.memwb_regwrite && (bus.memwb_rd != '0) && (bus.memwb_rd == ex_rs1))
      fwd_rs1 = bus.memwb_data;

    fwd_rs2 = ex_rs2_data;
    if (bus.exmem_regwrite && (bus.exmem_rd != '0) && (bus.exmem_rd == ex_rs2))
      fwd_rs2 = bus.exmem_data;
    else if (bus.memwb_regwrite && (bus.memwb_rd != '0) && (bus.memwb_rd == ex_rs2))
      fwd_rs2 = bus.memwb_data;
  end

  assign bus.alu_data1      = fwd_rs1;
  assign bus.alu_data2      = ex_alusrc ? ex_imm : fwd_rs2;
  assign bus.alu_ctrl       = ex_ctrl;
  assign bus.ex_store_data  = fwd_rs2;
  assign bus.ex_rd          = ex_rd;
  assign bus.ex_valid       = ex_valid;
  assign bus.ex_regwrite    = ex_regwrite;
  assign bus.ex_memread     = ex_memread;
  assign bus.ex_memwrite    = ex_memwrite;
  assign bus.ex_memtoreg    = ex_memtoreg;
  assign bus.load_use_stall = load_use;
  assign bus.bubble_cnt     = bubble_cnt;

endmodule
